// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the Z88 slot-0 asynchronous SRAM.
// The CPU port reads and writes; the LCD port only reads and gains priority after a bounded wait.
module sram_arbiter #(
  parameter int AW           = 19,
  parameter int RD_CYCLES    = 2,
  parameter int WR_CYCLES    = 2,
  parameter int LCD_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  input  logic          lcd_req,
  input  logic [AW-1:0] lcd_a,
  output logic [7:0]    lcd_rdata,
  output logic          lcd_ack,
  output logic [AW-1:0] sram_a,
  output logic [7:0]    sram_wdata,
  input  logic [7:0]    sram_rdata,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  localparam int CMAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int WW   = $clog2(LCD_MAX_WAIT + 1);

  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(LCD_MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    DONE
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cyc_cnt;
  logic [WW-1:0] wait_cnt;
  logic          owner_lcd;
  logic          grant_cpu, grant_lcd;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    grant_cpu  = 1'b0;
    grant_lcd  = 1'b0;
    case (state)
      IDLE: begin
        if (lcd_req && (!cpu_req || wait_cnt == WAIT_MAX)) begin
          grant_lcd  = 1'b1;
          next_state = RD;
        end else if (cpu_req) begin
          grant_cpu  = 1'b1;
          next_state = cpu_we ? WR_SETUP : RD;
        end
      end
      RD:       if (cyc_cnt == RD_LAST) next_state = DONE;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: if (cyc_cnt == WR_LAST) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state != next_state)
        cyc_cnt <= '0;
      else if (state == RD || state == WR_PULSE)
        cyc_cnt <= cyc_cnt + CW'(1);

      if (grant_lcd || !lcd_req)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Transaction latches and read-data capture; sram_a/sram_wdata hold between transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_lcd  <= 1'b0;
      sram_a     <= '0;
      sram_wdata <= '0;
      cpu_rdata  <= '0;
      lcd_rdata  <= '0;
    end else begin
      if (grant_lcd) begin
        owner_lcd <= 1'b1;
        sram_a    <= lcd_a;
      end else if (grant_cpu) begin
        owner_lcd  <= 1'b0;
        sram_a     <= cpu_a;
        sram_wdata <= cpu_wdata;
      end

      if (state == RD && next_state == DONE) begin
        if (owner_lcd) lcd_rdata <= sram_rdata;
        else           cpu_rdata <= sram_rdata;
      end
    end
  end

  // Strobes and acks are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      cpu_ack   <= 1'b0;
      lcd_ack   <= 1'b0;
    end else begin
      sram_ce_n <= !(next_state == RD || next_state == WR_SETUP || next_state == WR_PULSE);
      sram_oe_n <= (next_state != RD);
      sram_we_n <= (next_state != WR_PULSE);
      cpu_ack   <= (next_state == DONE) && !owner_lcd;
      lcd_ack   <= (next_state == DONE) && owner_lcd;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a default-parameter instance with an SRAM model and a
// fast instance (RD/WR_CYCLES=1, LCD_MAX_WAIT=1) with an address-derived read model.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int AW = 19;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]         cpu_req, cpu_we, lcd_req, cpu_ack, lcd_ack, ce_n, oe_n, we_n;
  logic [1:0][AW-1:0] cpu_a, lcd_a, sram_a;
  logic [1:0][7:0]    cpu_wdata, cpu_rdata, lcd_rdata, sram_wdata, sram_rdata;

  sram_arbiter #(.AW(AW), .RD_CYCLES(2), .WR_CYCLES(2), .LCD_MAX_WAIT(8)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_a(cpu_a[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
    .lcd_req(lcd_req[0]), .lcd_a(lcd_a[0]), .lcd_rdata(lcd_rdata[0]), .lcd_ack(lcd_ack[0]),
    .sram_a(sram_a[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0])
  );

  sram_arbiter #(.AW(AW), .RD_CYCLES(1), .WR_CYCLES(1), .LCD_MAX_WAIT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_a(cpu_a[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
    .lcd_req(lcd_req[1]), .lcd_a(lcd_a[1]), .lcd_rdata(lcd_rdata[1]), .lcd_ack(lcd_ack[1]),
    .sram_a(sram_a[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1])
  );

  // SRAM model for dut0: bench preloads go through the same process as strobed writes.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_a;
  logic [7:0]    pre_d;
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!ce_n[0] && !we_n[0]) mem[sram_a[0]] <= sram_wdata[0];
  end
  assign sram_rdata[0] = (!ce_n[0] && !oe_n[0]) ? mem[sram_a[0]] : 8'h00;

  logic [AW-1:0] wa1;
  logic [7:0]    wd1;
  always @(posedge clk) if (!ce_n[1] && !we_n[1]) begin wa1 <= sram_a[1]; wd1 <= sram_wdata[1]; end
  assign sram_rdata[1] = (!ce_n[1] && !oe_n[1]) ? (sram_a[1][7:0] ^ 8'h5A) : 8'h00;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int  lat;
    int  rd_low;
    int  we_low;
    int  setup;
    int  oe_in_wr;
    bit  other_ack;
    bit  hold_ok;
  } obs_t;

  typedef struct {
    bit            lcd;
    bit            we;
    logic [AW-1:0] a;
    logic [7:0]    wd;
    bit            pre;
    logic [7:0]    pd;
    logic [7:0]    exp;
    int            lat;
    int            pulse;
  } vec_t;

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One transaction on instance d; latency counts edges from raising req up to the ack sample.
  task automatic do_txn(input int d, input bit lcd, input bit we, input logic [AW-1:0] a,
                        input logic [7:0] wd, output obs_t o);
    bit own, other;
    o = '{default: 0};
    o.hold_ok = 1'b1;
    if (lcd) begin
      lcd_a[d] = a; lcd_req[d] = 1'b1;
    end else begin
      cpu_a[d] = a; cpu_we[d] = we; cpu_wdata[d] = wd; cpu_req[d] = 1'b1;
    end
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      own   = lcd ? lcd_ack[d] : cpu_ack[d];
      other = lcd ? cpu_ack[d] : lcd_ack[d];
      if (!ce_n[d] && !oe_n[d]) o.rd_low++;
      if (!ce_n[d] && !we_n[d]) o.we_low++;
      if (!ce_n[d] && we_n[d] && oe_n[d]) o.setup++;
      if (we && !oe_n[d]) o.oe_in_wr++;
      if ((!ce_n[d] || own) && (sram_a[d] !== a || (we && sram_wdata[d] !== wd))) o.hold_ok = 1'b0;
      if (other) o.other_ack = 1'b1;
      if (own) begin
        o.lat = e;
        break;
      end
    end
    cpu_req[d] = 1'b0;
    lcd_req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t        vecs [8];
  obs_t        o;
  logic [7:0]  exp_cpu_rd, exp_lcd_rd;
  logic [31:0] cm, lm;
  bit          both, ack_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pre_en = 1'b0; pre_a = '0; pre_d = '0;
    cpu_req = '0; cpu_we = '0; lcd_req = '0; cpu_a = '0; lcd_a = '0; cpu_wdata = '0;

    vecs[0] = '{lcd:1'b0, we:1'b0, a:19'h12345, wd:8'h00, pre:1'b1, pd:8'hA5, exp:8'hA5, lat:3, pulse:2};
    vecs[1] = '{lcd:1'b0, we:1'b1, a:19'h00010, wd:8'h3C, pre:1'b0, pd:8'h00, exp:8'h00, lat:4, pulse:2};
    vecs[2] = '{lcd:1'b1, we:1'b0, a:19'h7FFFF, wd:8'h00, pre:1'b1, pd:8'h5A, exp:8'h5A, lat:3, pulse:2};
    vecs[3] = '{lcd:1'b1, we:1'b0, a:19'h00000, wd:8'h00, pre:1'b1, pd:8'hC3, exp:8'hC3, lat:3, pulse:2};
    vecs[4] = '{lcd:1'b0, we:1'b0, a:19'h00010, wd:8'h00, pre:1'b0, pd:8'h00, exp:8'h3C, lat:3, pulse:2};
    vecs[5] = '{lcd:1'b1, we:1'b0, a:19'h7FFFF, wd:8'h00, pre:1'b1, pd:8'h81, exp:8'h81, lat:3, pulse:2};
    vecs[6] = '{lcd:1'b0, we:1'b1, a:19'h7FFFF, wd:8'h99, pre:1'b0, pd:8'h00, exp:8'h00, lat:4, pulse:2};
    vecs[7] = '{lcd:1'b1, we:1'b0, a:19'h7FFFF, wd:8'h00, pre:1'b0, pd:8'h00, exp:8'h99, lat:3, pulse:2};

    #12;
    check("reset strobes", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
    check("reset acks", {cpu_ack[0], lcd_ack[0], cpu_ack[1], lcd_ack[1]}, 4'b0000);
    check("reset sram_a", sram_a[0], 0);
    check("reset sram_wdata", sram_wdata[0], 0);
    check("reset rdata", {cpu_rdata[0], lcd_rdata[0]}, 16'h0000);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;

    exp_cpu_rd = 8'h00;
    exp_lcd_rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) preload(vecs[i].a, vecs[i].pd);
      do_txn(0, vecs[i].lcd, vecs[i].we, vecs[i].a, vecs[i].wd, o);
      if (!vecs[i].we) begin
        if (vecs[i].lcd) exp_lcd_rd = vecs[i].exp;
        else             exp_cpu_rd = vecs[i].exp;
      end
      check($sformatf("v%0d latency", i), o.lat, vecs[i].lat);
      check($sformatf("v%0d pulse", i), vecs[i].we ? o.we_low : o.rd_low, vecs[i].pulse);
      check($sformatf("v%0d other ack", i), {31'd0, o.other_ack}, 0);
      check($sformatf("v%0d addr/data hold", i), {31'd0, o.hold_ok}, 1);
      check($sformatf("v%0d cpu_rdata", i), cpu_rdata[0], exp_cpu_rd);
      check($sformatf("v%0d lcd_rdata", i), lcd_rdata[0], exp_lcd_rd);
      if (vecs[i].we) begin
        check($sformatf("v%0d setup", i), o.setup, 1);
        check($sformatf("v%0d oe in write", i), o.oe_in_wr, 0);
        check($sformatf("v%0d mem", i), mem[vecs[i].a], vecs[i].wd);
      end
    end

    // Starvation: both ports request continuously from reset.
    do_reset();
    cm = '0; lm = '0; both = 1'b0;
    cpu_a[0] = 19'h00100; cpu_we[0] = 1'b0; lcd_a[0] = 19'h00200;
    cpu_req[0] = 1'b1; lcd_req[0] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      cm[e] = cpu_ack[0];
      lm[e] = lcd_ack[0];
      if (cpu_ack[0] && lcd_ack[0]) both = 1'b1;
    end
    cpu_req[0] = 1'b0; lcd_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("starve cpu ack edges", cm, 32'h0008_8088);
    check("starve lcd ack edges", lm, 32'h0080_0800);
    check("starve simultaneous acks", {31'd0, both}, 0);

    // Reset in the middle of the write pulse.
    preload(19'h00020, 8'h11);
    cpu_a[0] = 19'h00020; cpu_we[0] = 1'b1; cpu_wdata[0] = 8'h77; cpu_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst: we_n low before reset", {31'd0, we_n[0]}, 0);
    #2 reset = 1'b1;
    #1;
    check("rst: strobes async high", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
    cpu_req[0] = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (cpu_ack[0] || lcd_ack[0]) ack_seen = 1'b1;
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    if (cpu_ack[0] || lcd_ack[0]) ack_seen = 1'b1;
    check("rst: no ack", {31'd0, ack_seen}, 0);
    check("rst: aborted write not stored", mem[19'h00020], 8'h11);
    do_txn(0, 1'b0, 1'b1, 19'h00020, 8'h77, o);
    check("rst: reissued write latency", o.lat, 4);
    check("rst: reissued write stored", mem[19'h00020], 8'h77);

    // Fast-parameter instance.
    do_txn(1, 1'b0, 1'b0, 19'h00042, 8'h00, o);
    check("fast read latency", o.lat, 2);
    check("fast read pulse", o.rd_low, 1);
    check("fast read data", cpu_rdata[1], 8'h18);
    do_txn(1, 1'b0, 1'b1, 19'h00055, 8'hE1, o);
    check("fast write latency", o.lat, 3);
    check("fast write pulse", o.we_low, 1);
    check("fast write setup", o.setup, 1);
    check("fast write addr", wa1, 19'h00055);
    check("fast write data", wd1, 8'hE1);

    cm = '0; lm = '0;
    cpu_a[1] = 19'h00001; cpu_we[1] = 1'b0; lcd_a[1] = 19'h00002;
    cpu_req[1] = 1'b1; lcd_req[1] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      cm[e] = cpu_ack[1];
      lm[e] = lcd_ack[1];
    end
    cpu_req[1] = 1'b0; lcd_req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fast starve cpu ack edges", cm, 32'h0000_0004);
    check("fast starve lcd ack edges", lm, 32'h0000_0020);
    check("fast starve lcd data", lcd_rdata[1], 8'h58);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
